// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - Rising-edge request arbiter granting requesters in FIFO order
// Optional macro FIFO_ARBITER_DEDUP_EN: skip candidates whose index is already queued.
module fifo_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int QDEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            request,
    input  logic                          clr_ovf,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count,
    output logic                          overflow_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_ANALYZE = 2'd1,
        S_ASSIGN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] ru_q;
    logic [NUM_REQ-1:0] fu_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_o_q;
    logic [IW-1:0]      queue_q [QDEPTH];
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [CW-1:0]      count_q;
    logic               overflow_q;

    logic [NUM_REQ-1:0] new_d;
    logic               cand_vld_d;
    logic [IW-1:0]      cand_idx_d;
    logic               cand_dup_d;
    logic [NUM_REQ-1:0] head_onehot_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Only the lowest newly-risen index competes; the rest of the rising set is dropped.
    always_comb begin
        new_d      = ru_q & ~fu_q;
        cand_vld_d = |new_d;
        cand_idx_d = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (new_d[i]) cand_idx_d = IW'(i);
        end
    end

`ifdef FIFO_ARBITER_DEDUP_EN
    logic [PW-1:0] dup_ptr;

    // Walk the valid entries from head so stale slots beyond count are ignored.
    always_comb begin
        cand_dup_d = 1'b0;
        dup_ptr    = head_q;
        for (int k = 0; k < QDEPTH; k++) begin
            if ((CW'(k) < count_q) && (queue_q[dup_ptr] == cand_idx_d)) cand_dup_d = 1'b1;
            dup_ptr = ptr_inc(dup_ptr);
        end
    end
`else
    always_comb begin
        cand_dup_d = 1'b0;
    end
`endif

    always_comb begin
        head_onehot_d = '0;
        head_onehot_d[queue_q[head_q]] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            ru_q       <= '0;
            fu_q       <= '0;
            grant_q    <= '0;
            grant_o_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) queue_q[i] <= '0;
        end else begin
            // A drop later in this block overrides the clear.
            if (clr_ovf) overflow_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    ru_q    <= request;
                    state_q <= S_ANALYZE;
                end
                S_ANALYZE: begin
                    grant_o_q <= grant_q;
                    fu_q      <= ru_q;
                    if (cand_vld_d && !cand_dup_d) begin
                        if (count_q < CW'(QDEPTH)) begin
                            queue_q[tail_q] <= cand_idx_d;
                            tail_q          <= ptr_inc(tail_q);
                            count_q         <= count_q + CW'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    state_q <= S_ASSIGN;
                end
                S_ASSIGN: begin
                    if (|fu_q) begin
                        if (count_q != '0) begin
                            grant_q <= head_onehot_d;
                            head_q  <= ptr_inc(head_q);
                            count_q <= count_q - CW'(1);
                        end else begin
                            grant_q <= '0;
                        end
                    end
                    ru_q    <= request;
                    state_q <= S_ANALYZE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign grant_o    = grant_o_q;
    assign q_count    = count_q;
    assign overflow_o = overflow_q;

endmodule
